mimo_demapper: RTL

Parametrised, pipelined hard-decision symbol demapper for the QR-based MIMO detector back end. Takes one vector of NS equalised complex estimates per handshake and returns one symbol index per stream, in axis-QPSK or 16-QAM Gray mode, selectable per vector. It replaces the fixed two-stream combinational demodulator and sits between the back-substitution stage and the bit sink. It adds valid/ready flow control, a 16-QAM mode, runtime decision thresholds and an optional zero-vector counter.

---
 rtl/mimo_demap_pkg.sv | 25 ++
 rtl/mimo_demapper_slice.sv | 64 ++++++
 rtl/mimo_demapper.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mimo_demap_pkg.sv
// mimo_demap_pkg: shared constants for the MIMO hard-decision demapper.
// Holds the mode encodings, the per-stream symbol width and the axis-QPSK
// symbol indices used by demap_slice and mimo_demapper.
package mimo_demap_pkg;

  // Per-vector modulation select, sampled with the input vector
  localparam logic MODE_QPSK  = 1'b0;
  localparam logic MODE_QAM16 = 1'b1;

  // Each stream's decision fits in one nibble of the output bus
  localparam int SYM_W = 4;

  // Erasure counter width and its saturation value
  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Axis-QPSK indices: east (+re), north (+im), south (-im), west (-re)
  typedef enum logic [1:0] {
    QPSK_E = 2'd0,
    QPSK_N = 2'd1,
    QPSK_S = 2'd2,
    QPSK_W = 2'd3
  } qpsk_idx_e;

endpackage

// File: rtl/mimo_demapper_slice.sv
// demap_slice: one spatial stream of the demapper.
// The front half turns a raw complex estimate into saturated magnitudes and
// sign bits (captured by the first pipeline stage in the top module); the
// back half turns those registered values into a symbol index and a
// zero-vector flag (captured by the second stage). No state lives here.
module demap_slice
  import mimo_demap_pkg::*;
#(
  parameter int W = 56
) (
  input  logic signed [W-1:0]     re,
  input  logic signed [W-1:0]     im,
  output logic        [W-1:0]     abs_re,
  output logic        [W-1:0]     abs_im,
  output logic                    neg_re,
  output logic                    neg_im,
  input  logic        [W-1:0]     q_abs_re,
  input  logic        [W-1:0]     q_abs_im,
  input  logic                    q_neg_re,
  input  logic                    q_neg_im,
  input  logic                    q_mode,
  input  logic        [W-1:0]     q_thr,
  output logic        [SYM_W-1:0] sym,
  output logic                    zero
);

  localparam logic [W-1:0] ABS_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  // Two's-complement magnitude; the most negative code has no positive twin,
  // so it is clamped to the largest positive value instead of wrapping.
  function automatic logic [W-1:0] sat_abs(input logic [W-1:0] v);
    if (!v[W-1]) begin
      return v;
    end else if (v == MOST_NEG) begin
      return ABS_MAX;
    end else begin
      return -v;
    end
  endfunction

  assign abs_re = sat_abs(re);
  assign abs_im = sat_abs(im);
  assign neg_re = re[W-1];
  assign neg_im = im[W-1];

  // A saturated magnitude is never zero, so zero magnitudes mean zero inputs
  assign zero = (q_abs_re == '0) && (q_abs_im == '0);

  // Hard decision from registered magnitudes, signs, mode and threshold
  always_comb begin
    sym = '0;
    if (zero) begin
      sym = '0;
    end else if (q_mode == MODE_QAM16) begin
      sym = {q_neg_re, (q_abs_re >= q_thr), q_neg_im, (q_abs_im >= q_thr)};
    end else if (q_abs_re >= q_abs_im) begin
      sym[1:0] = q_neg_re ? QPSK_W : QPSK_E;
    end else begin
      sym[1:0] = q_neg_im ? QPSK_S : QPSK_N;
    end
  end

endmodule

// File: rtl/mimo_demapper.sv
// mimo_demapper: pipelined hard-decision demapper for NS spatial streams.
// Stage 1 registers magnitudes, signs, mode and threshold; stage 2 registers
// the symbol vector. Both stages share one enable so a stalled output
// freezes the whole pipe, and in_ready is that same enable.
// Optional feature macro: DEMAP_ERASE_CNT_EN adds a saturating counter of
// transferred output vectors that contain at least one all-zero stream.
module mimo_demapper
  import mimo_demap_pkg::*;
#(
  parameter int W  = 56,
  parameter int NS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [W-1:0]          thr,
  input  logic [NS*W-1:0]       x_re,
  input  logic [NS*W-1:0]       x_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NS*SYM_W-1:0]   sym,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      erase_cnt
);

  logic                en;

  logic [NS*W-1:0]     pre_abs_re;
  logic [NS*W-1:0]     pre_abs_im;
  logic [NS-1:0]       pre_neg_re;
  logic [NS-1:0]       pre_neg_im;

  logic                s1_valid;
  logic                s1_mode;
  logic [W-1:0]        s1_thr;
  logic [NS*W-1:0]     s1_abs_re;
  logic [NS*W-1:0]     s1_abs_im;
  logic [NS-1:0]       s1_neg_re;
  logic [NS-1:0]       s1_neg_im;

  logic [NS*SYM_W-1:0] nxt_sym;
  logic [NS-1:0]       nxt_zero;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NS; k++) begin : g_slice
    demap_slice #(
      .W(W)
    ) u_slice (
      .re       (x_re[k*W +: W]),
      .im       (x_im[k*W +: W]),
      .abs_re   (pre_abs_re[k*W +: W]),
      .abs_im   (pre_abs_im[k*W +: W]),
      .neg_re   (pre_neg_re[k]),
      .neg_im   (pre_neg_im[k]),
      .q_abs_re (s1_abs_re[k*W +: W]),
      .q_abs_im (s1_abs_im[k*W +: W]),
      .q_neg_re (s1_neg_re[k]),
      .q_neg_im (s1_neg_im[k]),
      .q_mode   (s1_mode),
      .q_thr    (s1_thr),
      .sym      (nxt_sym[k*SYM_W +: SYM_W]),
      .zero     (nxt_zero[k])
    );
  end

  // Stage 1: capture magnitudes, signs and per-vector controls when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_QPSK;
      s1_thr    <= '0;
      s1_abs_re <= '0;
      s1_abs_im <= '0;
      s1_neg_re <= '0;
      s1_neg_im <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_mode   <= mode;
      s1_thr    <= thr;
      s1_abs_re <= pre_abs_re;
      s1_abs_im <= pre_abs_im;
      s1_neg_re <= pre_neg_re;
      s1_neg_im <= pre_neg_im;
    end
  end

  // Stage 2: capture the decided symbol vector and its valid when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sym       <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      sym       <= nxt_sym;
    end
  end

`ifdef DEMAP_ERASE_CNT_EN
  logic             out_zero;
  logic [CNT_W-1:0] cnt_q;

  // Stage 2 companion flag: the held symbol vector has an all-zero stream
  always_ff @(posedge clk) begin
    if (rst) begin
      out_zero <= 1'b0;
    end else if (en) begin
      out_zero <= |nxt_zero;
    end
  end

  // Saturating erasure counter; a clear beats a coincident increment
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && out_zero && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign erase_cnt = cnt_q;
`else
  logic unused_erase;

  assign unused_erase = cnt_clr ^ (|nxt_zero);
  assign erase_cnt    = '0;
`endif

endmodule
